// File: rtl/curve_lut_pkg.sv
// Shared widths and loader state encoding for the programmable contrast curve.
package curve_lut_pkg;

  localparam int unsigned DATA_WIDTH = 8;
  localparam int unsigned DEPTH      = 2 ** DATA_WIDTH;
  localparam int unsigned ADDR_WIDTH = DATA_WIDTH + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    PEND = 2'd2
  } state_t;

endpackage

// File: rtl/curve_lut_dpram.sv
// Two-bank curve storage: one synchronous write port, one registered read port.
module curve_lut_dpram
  import curve_lut_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [2*DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Array contents are left unreset; only the output register is cleared.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data <= '0;
    end else begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/curve_lut_loader.sv
// Host-loadable grey-level curve with shadow bank swapped at frame start.
// Optional macro CURVE_LUT_IDENTITY_EN: pass pixels through unmapped until the first swap.
module curve_lut_loader
  import curve_lut_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [DATA_WIDTH-1:0] cfg_data,
  input  logic                  cfg_last,
  output logic                  load_done,
  output logic                  load_err,
  output logic                  swap_pending,
  input  logic                  per_frame_vsync,
  input  logic                  per_frame_href,
  input  logic                  per_frame_clken,
  input  logic [DATA_WIDTH-1:0] per_img_gray,
  output logic                  post_frame_vsync,
  output logic                  post_frame_href,
  output logic                  post_frame_clken,
  output logic [DATA_WIDTH-1:0] post_img_gray
);

  localparam logic [DATA_WIDTH-1:0] CNT_MAX = DATA_WIDTH'(DEPTH - 1);

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] cnt_q, cnt_d;
  logic                  bank_sel_q, bank_sel_d;
  logic                  vsync_d_q;
  logic                  load_done_d, load_err_d;
  logic                  cfg_ready_d, swap_pending_d;
  logic                  accept_c;
  logic                  fs_c;
  logic [DATA_WIDTH-1:0] ram_q;

  assign accept_c = cfg_valid & cfg_ready;
  assign fs_c     = per_frame_vsync & ~vsync_d_q;

  // Loader state, counter, bank select and registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      bank_sel_q   <= 1'b0;
      vsync_d_q    <= 1'b0;
      load_done    <= 1'b0;
      load_err     <= 1'b0;
      cfg_ready    <= 1'b1;
      swap_pending <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bank_sel_q   <= bank_sel_d;
      vsync_d_q    <= per_frame_vsync;
      load_done    <= load_done_d;
      load_err     <= load_err_d;
      cfg_ready    <= cfg_ready_d;
      swap_pending <= swap_pending_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bank_sel_d  = bank_sel_q;
    load_done_d = 1'b0;
    load_err_d  = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (accept_c) begin
          if (cfg_last) begin
            load_err_d = 1'b1;
          end else begin
            state_d = LOAD;
            cnt_d   = DATA_WIDTH'(1);
          end
        end
      end
      LOAD: begin
        if (accept_c) begin
          if (cnt_q == CNT_MAX) begin
            load_done_d = 1'b1;
            state_d     = PEND;
            cnt_d       = '0;
          end else if (cfg_last) begin
            load_err_d = 1'b1;
            state_d    = IDLE;
            cnt_d      = '0;
          end else begin
            cnt_d = cnt_q + DATA_WIDTH'(1);
          end
        end
      end
      PEND: begin
        if (fs_c) begin
          bank_sel_d = ~bank_sel_q;
          state_d    = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    cfg_ready_d    = (state_d != PEND);
    swap_pending_d = (state_d == PEND);
  end

  // Writes go to the shadow bank, reads to the active bank: never the same bank.
  curve_lut_dpram u_dpram (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (accept_c),
    .wr_addr ({~bank_sel_q, cnt_q}),
    .wr_data (cfg_data),
    .rd_addr ({bank_sel_q, per_img_gray}),
    .rd_data (ram_q)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      post_frame_vsync <= 1'b0;
      post_frame_href  <= 1'b0;
      post_frame_clken <= 1'b0;
    end else begin
      post_frame_vsync <= per_frame_vsync;
      post_frame_href  <= per_frame_href;
      post_frame_clken <= per_frame_clken;
    end
  end

`ifdef CURVE_LUT_IDENTITY_EN
  logic                  table_valid_q;
  logic                  map_sel_q;
  logic [DATA_WIDTH-1:0] gray_q;

  // Identity select is captured alongside the RAM read so both halves share latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      table_valid_q <= 1'b0;
      map_sel_q     <= 1'b0;
      gray_q        <= '0;
    end else begin
      if ((state_q == PEND) && fs_c) begin
        table_valid_q <= 1'b1;
      end
      map_sel_q <= table_valid_q;
      gray_q    <= per_img_gray;
    end
  end

  assign post_img_gray = map_sel_q ? ram_q : gray_q;
`else
  assign post_img_gray = ram_q;
`endif

endmodule

// File: tb/tb_curve_lut_loader.sv
// Randomized self-checking bench for curve_lut_loader against a table-level model.
module tb_curve_lut_loader;
  import curve_lut_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  cfg_valid;
  logic                  cfg_ready;
  logic [DATA_WIDTH-1:0] cfg_data;
  logic                  cfg_last;
  logic                  load_done;
  logic                  load_err;
  logic                  swap_pending;
  logic                  per_frame_vsync;
  logic                  per_frame_href;
  logic                  per_frame_clken;
  logic [DATA_WIDTH-1:0] per_img_gray;
  logic                  post_frame_vsync;
  logic                  post_frame_href;
  logic                  post_frame_clken;
  logic [DATA_WIDTH-1:0] post_img_gray;

  curve_lut_loader dut (
    .clk              (clk),
    .rst              (rst),
    .cfg_valid        (cfg_valid),
    .cfg_ready        (cfg_ready),
    .cfg_data         (cfg_data),
    .cfg_last         (cfg_last),
    .load_done        (load_done),
    .load_err         (load_err),
    .swap_pending     (swap_pending),
    .per_frame_vsync  (per_frame_vsync),
    .per_frame_href   (per_frame_href),
    .per_frame_clken  (per_frame_clken),
    .per_img_gray     (per_img_gray),
    .post_frame_vsync (post_frame_vsync),
    .post_frame_href  (post_frame_href),
    .post_frame_clken (post_frame_clken),
    .post_img_gray    (post_img_gray)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int done_cnt = 0;
  int err_cnt  = 0;

  // Model: active curve, shadow curve being loaded, and a pending-swap flag.
  logic [7:0] m_active [256];
  logic [7:0] m_shadow [256];
  logic [7:0] m_tbl    [256];
  bit         m_pending;
  bit         m_tv;
  bit         m_vs_d;

  task automatic tick();
    bit fs;
    fs = (per_frame_vsync === 1'b1) && !m_vs_d;
    @(posedge clk);
    #1;
    if (load_done === 1'b1) done_cnt++;
    if (load_err === 1'b1) err_cnt++;
    if (fs && m_pending) begin
      m_active  = m_shadow;
      m_pending = 1'b0;
      m_tv      = 1'b1;
    end
    m_vs_d = (per_frame_vsync === 1'b1);
  endtask

  task automatic load_table(input int n_beats, input bit coincide_vs);
    done_cnt = 0;
    err_cnt  = 0;
    for (int k = 0; k < n_beats; k++) begin
      while ($urandom_range(0, 3) == 0) begin
        cfg_valid = 1'b0;
        cfg_data  = 8'($urandom);
        tick();
      end
      cfg_valid = 1'b1;
      cfg_data  = m_tbl[k];
      cfg_last  = (k == n_beats - 1);
      if (coincide_vs && (k == n_beats - 1)) per_frame_vsync = 1'b1;
      n_checks++;
      if (cfg_ready !== 1'b1) $display("FAIL cfg_ready_during_load beat %0d: got %b exp 1", k, cfg_ready);
      else n_pass++;
      tick();
      m_shadow[k] = m_tbl[k];
    end
    cfg_valid = 1'b0;
    cfg_last  = 1'b0;
    if (n_beats == DEPTH) m_pending = 1'b1;
    tick();
  endtask

  task automatic pixel_once(input logic [7:0] g);
    logic [7:0] exp_g;
    logic       vs;
    per_frame_href  = 1'b1;
    per_frame_clken = 1'b1;
    per_img_gray    = g;
    exp_g = m_active[g];
`ifdef CURVE_LUT_IDENTITY_EN
    if (!m_tv) exp_g = g;
`endif
    vs = per_frame_vsync;
    tick();
    n_checks++;
    if (post_img_gray !== exp_g) $display("FAIL pixel_map in=%h: got %h exp %h", g, post_img_gray, exp_g);
    else n_pass++;
    n_checks++;
    if (post_frame_clken !== 1'b1 || post_frame_href !== 1'b1 || post_frame_vsync !== vs)
      $display("FAIL sync_delay: got clken=%b href=%b vsync=%b exp 1 1 %b",
               post_frame_clken, post_frame_href, post_frame_vsync, vs);
    else n_pass++;
    per_frame_clken = 1'b0;
    per_frame_href  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cfg_valid = 1'b0; cfg_data = '0; cfg_last = 1'b0;
    per_frame_vsync = 1'b0; per_frame_href = 1'b0; per_frame_clken = 1'b0; per_img_gray = '0;
    m_pending = 1'b0; m_tv = 1'b0; m_vs_d = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
    n_checks++;
    if (cfg_ready !== 1'b1) $display("FAIL reset_cfg_ready: got %b exp 1", cfg_ready);
    else n_pass++;
    n_checks++;
    if ({load_done, load_err, swap_pending} !== 3'b000)
      $display("FAIL reset_status: got done=%b err=%b pend=%b exp 0 0 0", load_done, load_err, swap_pending);
    else n_pass++;
    n_checks++;
    if ({post_frame_vsync, post_frame_href, post_frame_clken} !== 3'b000 || post_img_gray !== 8'h00)
      $display("FAIL reset_post: got sync=%b%b%b gray=%h exp 000 00",
               post_frame_vsync, post_frame_href, post_frame_clken, post_img_gray);
    else n_pass++;
  endtask

`ifdef CURVE_LUT_IDENTITY_EN
  task automatic test_identity();
    pixel_once(8'h40);
    for (int i = 0; i < 4; i++) pixel_once(8'($urandom));
  endtask
`endif

  task automatic test_full_load();
    for (int k = 0; k < 256; k++) m_tbl[k] = 8'(255 - k);
    load_table(256, 1'b0);
    n_checks++;
    if (done_cnt != 1 || err_cnt != 0) $display("FAIL full_load_pulses: got done=%0d err=%0d exp 1 0", done_cnt, err_cnt);
    else n_pass++;
    n_checks++;
    if (swap_pending !== 1'b1 || cfg_ready !== 1'b0)
      $display("FAIL full_load_pend: got pend=%b ready=%b exp 1 0", swap_pending, cfg_ready);
    else n_pass++;
    cfg_valid = 1'b1;
    cfg_data  = 8'($urandom);
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (cfg_ready !== 1'b0) $display("FAIL pend_blocks_beats: got ready=%b exp 0", cfg_ready);
      else n_pass++;
      tick();
    end
    cfg_valid = 1'b0;
    n_checks++;
    if (swap_pending !== 1'b1 || done_cnt != 1)
      $display("FAIL pend_hold: got pend=%b done=%0d exp 1 1", swap_pending, done_cnt);
    else n_pass++;
    per_frame_vsync = 1'b1;
    tick();
    n_checks++;
    if (swap_pending !== 1'b0 || cfg_ready !== 1'b1)
      $display("FAIL swap_on_fs: got pend=%b ready=%b exp 0 1", swap_pending, cfg_ready);
    else n_pass++;
    pixel_once(8'h00);
    pixel_once(8'h7F);
    pixel_once(8'hFF);
    for (int i = 0; i < 8; i++) pixel_once(8'($urandom));
    per_frame_vsync = 1'b0;
    tick();
  endtask

  task automatic test_early_last();
    for (int k = 0; k < 256; k++) m_tbl[k] = 8'($urandom);
    load_table(101, 1'b0);
    n_checks++;
    if (err_cnt != 1 || done_cnt != 0) $display("FAIL early_last_pulses: got err=%0d done=%0d exp 1 0", err_cnt, done_cnt);
    else n_pass++;
    n_checks++;
    if (swap_pending !== 1'b0 || cfg_ready !== 1'b1)
      $display("FAIL early_last_idle: got pend=%b ready=%b exp 0 1", swap_pending, cfg_ready);
    else n_pass++;
    per_frame_vsync = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) pixel_once(8'($urandom));
    per_frame_vsync = 1'b0;
    tick();
  endtask

  task automatic test_midframe_load();
    per_frame_vsync = 1'b1;
    tick();
    for (int k = 0; k < 256; k++) m_tbl[k] = 8'($urandom);
    load_table(256, 1'b0);
    n_checks++;
    if (swap_pending !== 1'b1 || done_cnt != 1)
      $display("FAIL midframe_pend: got pend=%b done=%0d exp 1 1", swap_pending, done_cnt);
    else n_pass++;
    for (int i = 0; i < 6; i++) pixel_once(8'($urandom));
    per_frame_vsync = 1'b0;
    tick();
    n_checks++;
    if (swap_pending !== 1'b1) $display("FAIL midframe_no_swap_on_fall: got %b exp 1", swap_pending);
    else n_pass++;
    per_frame_vsync = 1'b1;
    tick();
    n_checks++;
    if (swap_pending !== 1'b0) $display("FAIL midframe_swap: got %b exp 0", swap_pending);
    else n_pass++;
    for (int i = 0; i < 6; i++) pixel_once(8'($urandom));
    per_frame_vsync = 1'b0;
    tick();
  endtask

  task automatic test_coincident_fs();
    tick();
    for (int k = 0; k < 256; k++) m_tbl[k] = 8'($urandom);
    load_table(256, 1'b1);
    n_checks++;
    if (swap_pending !== 1'b1) $display("FAIL coincident_no_swap: got %b exp 1", swap_pending);
    else n_pass++;
    for (int i = 0; i < 6; i++) pixel_once(8'($urandom));
    per_frame_vsync = 1'b0;
    tick();
    per_frame_vsync = 1'b1;
    tick();
    n_checks++;
    if (swap_pending !== 1'b0) $display("FAIL coincident_next_swap: got %b exp 0", swap_pending);
    else n_pass++;
    for (int i = 0; i < 6; i++) pixel_once(8'($urandom));
    per_frame_vsync = 1'b0;
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
`ifdef CURVE_LUT_IDENTITY_EN
    test_identity();
`endif
    test_full_load();
    test_early_last();
    test_midframe_load();
    test_coincident_fs();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/curve_lut_loader.md
Name: curve_lut_loader

Overview:
- Run-time programmable 256-entry grey-level contrast curve. Replaces the fixed curve lookup in the image-contrast pipeline.
- A host writes a new table over a valid/ready stream into a shadow bank.
- The shadow bank becomes active only at the next frame start, so a frame never mixes two curves.
- Pixel path sits between the grey-conversion stage and the downstream image sink, with fixed 1-cycle latency.

Parameters:
- DATA_WIDTH, 8, pixel and table-entry width.
- DEPTH, 256, entries per bank; always 2**DATA_WIDTH.

Ports:
- clk  in  1  system clock; every register is on its rising edge.
- rst  in  1  reset, asynchronous, active-high.
- cfg_valid  in  1  host table beat valid.
- cfg_ready  out  1  loader can accept a beat.
- cfg_data  in  DATA_WIDTH  table entry; beat k is the output value for input grey k.
- cfg_last  in  1  host marks final beat.
- load_done  out  1  1-cycle pulse on acceptance of beat 255.
- load_err  out  1  1-cycle pulse on an early cfg_last.
- swap_pending  out  1  complete table waiting for a frame start.
- per_frame_vsync  in  1  input frame sync; high during the frame.
- per_frame_href  in  1  input line valid.
- per_frame_clken  in  1  input pixel strobe.
- per_img_gray  in  DATA_WIDTH  input grey pixel.
- post_frame_vsync  out  1  per_frame_vsync delayed 1 cycle.
- post_frame_href  out  1  per_frame_href delayed 1 cycle.
- post_frame_clken  out  1  per_frame_clken delayed 1 cycle.
- post_img_gray  out  DATA_WIDTH  mapped pixel.

Behaviour:
- Reset values: all outputs 0 except cfg_ready=1. State=IDLE, beat counter=0, bank_sel=0, vsync_d=0. RAM contents are not reset.
- Beat accepted when cfg_valid & cfg_ready. Each accepted beat writes cfg_data to address {~bank_sel, cnt}, then cnt increments.
- IDLE: cfg_ready=1, cnt=0. An accepted beat moves the FSM to LOAD (that beat is entry 0).
- LOAD: cfg_ready=1.
  - Accepted beat with cnt=255: load_done pulses next cycle, FSM goes to PEND, cnt wraps to 0.
  - cfg_last on a beat with cnt<255: that beat is written, load_err pulses, FSM returns to IDLE, no swap is armed.
  - cfg_last absent on beat 255: accepted anyway, no error.
  - Gaps in cfg_valid stall the counter; no timeout.
- PEND: cfg_ready=0, swap_pending=1.
  - Frame-start edge is fs = per_frame_vsync & ~vsync_d.
  - On fs in PEND: bank_sel toggles at the end of that cycle, FSM goes to IDLE.
  - fs arriving in the same cycle as the final LOAD beat does not swap; the swap waits for the next fs.
- Pixel path:
  - Registered read of address {bank_sel, per_img_gray}, using bank_sel as it stands in the read cycle.
  - post_img_gray is valid one cycle after per_frame_clken and is updated every cycle regardless of clken.
  - post_frame_* equal the per_frame_* inputs delayed one cycle; both paths have identical latency.
- Reads and writes always target opposite banks, so no read/write collision exists.
- Reset mid-load: FSM goes to IDLE and bank_sel to 0. The partially written shadow bank is discarded because the next load rewrites all 256 entries.

Optional Feature:
- Macro CURVE_LUT_IDENTITY_EN.
- Defined: a flag table_valid resets to 0 and is set on the first swap. While it is 0, post_img_gray is per_img_gray registered (identity, same 1-cycle latency).
- Undefined: post_img_gray is always the RAM read data; before the first swap it is undefined (X in simulation).

Decomposition:
- Package curve_lut_pkg holds DATA_WIDTH, DEPTH, and the state enum {IDLE, LOAD, PEND}.
- One sub-module: curve_lut_dpram.
  - Simple dual-port RAM, 2*DEPTH x DATA_WIDTH; bank is the address MSB.
  - One synchronous write port, one read port with registered output.
- FSM, counter, edge detect and sync delay live in the top module.

Test Plan:
- Reset with CURVE_LUT_IDENTITY_EN, no load: gray 0x40 with clken -> post_img_gray=0x40 one cycle later, post_frame_clken=1 the same cycle.
- Load table entry[k]=255-k (256 beats, cfg_last on beat 255) -> load_done pulse, swap_pending=1. Then vsync rises -> swap_pending=0; in the frame, 0x00->0xFF, 0x7F->0x80, 0xFF->0x00.
- Random cfg_valid gaps during load -> exactly 256 writes, load_done once. Beats offered while in PEND are not accepted (cfg_ready=0).
- cfg_last on beat 100 -> load_err pulse, FSM in IDLE, swap_pending=0; next vsync rise leaves the mapping unchanged.
- Load completes mid-frame (vsync high) -> rest of the frame uses the old table; the new table applies from the next vsync rise.
- Final beat coincides with the vsync rising edge -> no swap on that edge; swap on the following rising edge.
